// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD MM:SS countdown timer.
// Packing of a time word: {min_tens, min_ones, sec_tens, sec_ones}.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  localparam int DIGIT_W      = 4;
  localparam int N_DIGITS     = 4;
  localparam int SEC_TENS_MAX = 5;
  localparam int DIGIT_MAX    = 9;

  localparam int SEC_ONES = 0;
  localparam int SEC_TENS = 1;
  localparam int MIN_ONES = 2;
  localparam int MIN_TENS = 3;

  function automatic logic [DIGIT_W-1:0] clamp_digit(
    input logic [DIGIT_W-1:0] d,
    input logic [DIGIT_W-1:0] max
  );
    return (d > max) ? max : d;
  endfunction

  function automatic logic [15:0] clamp_time(input logic [15:0] t);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      r[i*DIGIT_W +: DIGIT_W] = clamp_digit(
        t[i*DIGIT_W +: DIGIT_W],
        (i == SEC_TENS) ? DIGIT_W'(SEC_TENS_MAX)
                        : DIGIT_W'(DIGIT_MAX));
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with load, clamp and borrow chaining.
// Ports: clk, reset, load, d (load value), dec_in (borrow request),
//        q (digit), borrow_out (dec_in while digit is zero).
module bcd_down_digit
  import bcd_timer_pkg::*;
#(
  parameter int MAX = DIGIT_MAX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DIGIT_W-1:0] d,
  input  logic               dec_in,
  output logic [DIGIT_W-1:0] q,
  output logic               borrow_out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= clamp_digit(d, DIGIT_W'(MAX));
    end else if (dec_in) begin
      q <= (q == '0) ? DIGIT_W'(MAX) : q - DIGIT_W'(1);
    end
  end

  assign borrow_out = dec_in & (q == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer with one-second prescaler and expiry flags.
// Ports: clk, reset (sync, active-high), load/ld_value, start, stop,
//        q (BCD time), running, done (sticky), expire (1-cycle pulse).
// Option: define AUTO_RELOAD_EN to reload the last loaded time on expiry.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int TICK_DIV = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] ld_value,
  input  logic        start,
  input  logic        stop,
  output logic [15:0] q,
  output logic        running,
  output logic        done,
  output logic        expire
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_t state, state_n;
  logic [PW-1:0] presc;
  logic [N_DIGITS:0] borrow;
  logic [15:0] dig_d;
  logic tick, expiring, reload, auto_ok;
  logic start_zero, expire_n;

`ifdef AUTO_RELOAD_EN
  logic [15:0] shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= clamp_time(ld_value);
    end
  end

  // A zero shadow means there is nothing to reload: plain expiry.
  assign auto_ok = (shadow != '0);
  assign dig_d   = load ? ld_value : shadow;
`else
  assign auto_ok = 1'b0;
  assign dig_d   = ld_value;
`endif

  // Load and stop both suppress the tick on the edge they occur.
  assign tick = (state == RUN) && !load && !stop
             && (presc == PRE_LAST);

  assign borrow[0] = tick;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
    bcd_down_digit #(
      .MAX(i == SEC_TENS ? SEC_TENS_MAX : DIGIT_MAX)
    ) u_dig (
      .clk       (clk),
      .reset     (reset),
      .load      (load | reload),
      .d         (dig_d[i*DIGIT_W +: DIGIT_W]),
      .dec_in    (borrow[i]),
      .q         (q[i*DIGIT_W +: DIGIT_W]),
      .borrow_out(borrow[i+1])
    );
  end

  // Decrementing 00:01 is the only way to reach 00:00; a borrow out
  // of the top digit would be an underflow and is treated the same.
  assign expiring = tick & ((q == 16'h0001) | borrow[N_DIGITS]);
  assign reload   = expiring & auto_ok;

  assign start_zero = (state == IDLE) && start && !stop && !load
                   && (q == '0);
  assign expire_n   = expiring | start_zero;

  always_comb begin
    state_n = state;
    if (load) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !stop) state_n = (q == '0) ? DONE : RUN;
        end
        RUN: begin
          if (stop) state_n = PAUSED;
          else if (expiring && !reload) state_n = DONE;
        end
        PAUSED: begin
          if (start && !stop) state_n = RUN;
        end
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      presc  <= '0;
      expire <= 1'b0;
    end else begin
      state  <= state_n;
      expire <= expire_n;
      if (load || state == IDLE) begin
        presc <= '0;
      end else if (state == RUN && !stop) begin
        presc <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
      end
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer (TICK_DIV = 4).
// Expected outputs come from a seconds-based model via a scoreboard queue.
module tb_bcd_countdown_timer;

  localparam int TD = 4;
`ifdef AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, load, start, stop;
  logic [15:0] ld_value;
  logic [15:0] q;
  logic running, done, expire;

  bcd_countdown_timer #(.TICK_DIV(TD)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .ld_value(ld_value),
    .start   (start),
    .stop    (stop),
    .q       (q),
    .running (running),
    .done    (done),
    .expire  (expire)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] q;
    logic        run;
    logic        dn;
    logic        ex;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;

  int m_st = 0;
  int m_sec = 0;
  int m_pre = 0;
  int m_shadow = 0;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
  endtask

  function automatic int to_sec(input logic [15:0] v);
    int mt, mo, st, so;
    mt = int'(v[15:12]);
    mo = int'(v[11:8]);
    st = int'(v[7:4]);
    so = int'(v[3:0]);
    if (mt > 9) mt = 9;
    if (mo > 9) mo = 9;
    if (st > 5) st = 5;
    if (so > 9) so = 9;
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int m, r;
    m = s / 60;
    r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  // Drive one cycle, advance the model and queue what the DUT must show.
  task automatic step(input logic rs, input logic ld,
                      input logic [15:0] v, input logic st,
                      input logic sp);
    logic e;
    reset = rs;
    load = ld;
    ld_value = v;
    start = st;
    stop = sp;
    e = 1'b0;
    if (rs) begin
      m_st = 0; m_sec = 0; m_pre = 0; m_shadow = 0;
    end else if (ld) begin
      m_sec = to_sec(v); m_shadow = m_sec; m_pre = 0; m_st = 0;
    end else begin
      case (m_st)
        0: if (!sp && st) begin
          if (m_sec == 0) begin m_st = 3; e = 1'b1; end
          else begin m_st = 1; m_pre = 0; end
        end
        1: if (sp) m_st = 2;
        else if (m_pre == TD - 1) begin
          m_pre = 0;
          m_sec--;
          if (m_sec == 0) begin
            e = 1'b1;
            if (AUTO && m_shadow != 0) m_sec = m_shadow;
            else m_st = 3;
          end
        end else m_pre++;
        2: if (!sp && st) m_st = 1;
        default: ;
      endcase
    end
    sb.push_back('{q: to_bcd(m_sec), run: (m_st == 1),
                   dn: (m_st == 3), ex: e});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("sb_q", q, e.q);
      check("sb_running", {15'b0, running}, {15'b0, e.run});
      check("sb_done", {15'b0, done}, {15'b0, e.dn});
      check("sb_expire", {15'b0, expire}, {15'b0, e.ex});
    end
  end

  initial begin
    reset = 1'b1;
    load = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    ld_value = 16'h0;
    @(negedge clk);
    step(1, 0, 16'h0, 0, 0);
    step(1, 0, 16'h0, 0, 0);
    check("rst_q", q, 16'h0000);
    check("rst_flags", {13'b0, running, done, expire}, 16'h0);

    step(0, 1, 16'h0102, 0, 0);
    check("ld_0102", q, 16'h0102);
    step(0, 0, 16'h0, 1, 0);
    check("t1_running", {15'b0, running}, 16'h1);
    idle(4);
    check("t1_0101", q, 16'h0101);
    idle(4);
    check("t1_0100", q, 16'h0100);
    idle(4);
    check("t1_borrow_0059", q, 16'h0059);

    step(0, 1, 16'h0002, 0, 0);
    step(0, 0, 16'h0, 1, 0);
    idle(4);
    check("t2_0001", q, 16'h0001);
    idle(4);
    check("t2_expire_hi", {15'b0, expire}, 16'h1);
    if (AUTO) begin
      check("t2_reload_q", q, 16'h0002);
      check("t2_reload_done", {15'b0, done}, 16'h0);
      check("t2_reload_run", {15'b0, running}, 16'h1);
    end else begin
      check("t2_zero_q", q, 16'h0000);
      check("t2_done", {15'b0, done}, 16'h1);
    end
    idle(1);
    check("t2_expire_lo", {15'b0, expire}, 16'h0);
    step(0, 0, 16'h0, 1, 0);
    if (!AUTO) begin
      check("t2_done_sticky", {15'b0, done}, 16'h1);
      check("t2_start_ign", {15'b0, running}, 16'h0);
    end

    step(0, 1, 16'h0030, 0, 0);
    step(0, 0, 16'h0, 1, 0);
    idle(2);
    repeat (10) step(0, 0, 16'h0, 0, 1);
    check("t3_frozen", q, 16'h0030);
    check("t3_paused", {15'b0, running}, 16'h0);
    step(0, 0, 16'h0, 1, 0);
    idle(1);
    check("t3_resume_hold", q, 16'h0030);
    idle(1);
    check("t3_resume_dec", q, 16'h0029);

    step(0, 1, 16'h7A9F, 0, 0);
    check("t4_clamp", q, 16'h7959);
    step(0, 1, 16'h0000, 0, 0);
    step(0, 0, 16'h0, 1, 0);
    check("t4_zero_expire", {15'b0, expire}, 16'h1);
    check("t4_zero_done", {15'b0, done}, 16'h1);
    idle(1);
    check("t4_zero_pulse", {15'b0, expire}, 16'h0);

    step(0, 1, 16'h0100, 0, 0);
    step(0, 0, 16'h0, 1, 1);
    check("t5_ss_idle", {15'b0, running}, 16'h0);
    step(0, 0, 16'h0, 1, 0);
    idle(3);
    step(0, 1, 16'h0500, 0, 0);
    check("t5_ld_tick_q", q, 16'h0500);
    check("t5_ld_tick_idle", {15'b0, running}, 16'h0);
    idle(4);
    check("t5_no_dec", q, 16'h0500);
    step(0, 0, 16'h0, 1, 0);
    idle(2);
    step(0, 0, 16'h0, 1, 1);
    check("t5_ss_run", {15'b0, running}, 16'h0);
    step(0, 0, 16'h0, 1, 0);
    idle(5);
    step(1, 0, 16'h0, 0, 0);
    check("t5_rst_q", q, 16'h0000);
    check("t5_rst_flags", {13'b0, running, done, expire}, 16'h0);

    repeat (600) begin
      logic rs, ld, st, sp;
      logic [15:0] v;
      rs = ($urandom_range(0, 99) == 0);
      ld = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 3) == 0);
      sp = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) v = 16'($urandom());
      else v = {8'h00, 4'($urandom_range(0, 2)),
                4'($urandom_range(0, 9))};
      step(rs, ld, v, st, sp);
    end
    step(0, 0, 16'h0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
